// File: rtl/ahbl_cmd_master.sv
// AHB-Lite single-transfer initiator fed by a valid/ready command stream.
// Optional data-phase timeout: define AHBL_CMD_MASTER_TIMEOUT_EN.
module ahbl_cmd_master #(
  parameter int unsigned TIMEOUT   = 256,
  parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic        HRESP
`ifdef AHBL_CMD_MASTER_TIMEOUT_EN
  ,
  output logic        timeout_flag
`endif
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  logic        ap_valid_q, ap_valid_d;
  logic [31:0] ap_addr_q, ap_addr_d;
  logic        ap_write_q, ap_write_d;
  logic [1:0]  ap_size_q, ap_size_d;
  logic        ap_ill_q, ap_ill_d;
  logic [31:0] ap_wdata_q, ap_wdata_d;

  logic        dp_valid_q, dp_valid_d;
  logic        dp_write_q, dp_write_d;
  logic        dp_ill_q, dp_ill_d;
  logic [31:0] dp_wdata_q, dp_wdata_d;

  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] addr_al;
  logic        accept;

`ifdef AHBL_CMD_MASTER_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

  logic [15:0] cnt_q, cnt_d;
  logic        rec_q, rec_d;
  logic        rec_ap_q, rec_ap_d;
  logic        rec_wr_q, rec_wr_d;
  logic        flag_q, flag_d;

  assign cmd_ready    = HREADY & ~rec_q;
  assign timeout_flag = flag_q;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT != 0) ^ (^ERR_RDATA);
  assign cmd_ready  = HREADY;
`endif

  assign accept = cmd_valid & cmd_ready;

  always_comb begin
    unique case (1'b1)
      cmd_size == 2'd0: addr_al = cmd_addr;
      cmd_size == 2'd1: addr_al = {cmd_addr[31:1], 1'b0};
      default:          addr_al = {cmd_addr[31:2], 2'b00};
    endcase
  end

  always_comb begin
    ap_valid_d  = ap_valid_q;
    ap_addr_d   = ap_addr_q;
    ap_write_d  = ap_write_q;
    ap_size_d   = ap_size_q;
    ap_ill_d    = ap_ill_q;
    ap_wdata_d  = ap_wdata_q;
    dp_valid_d  = dp_valid_q;
    dp_write_d  = dp_write_q;
    dp_ill_d    = dp_ill_q;
    dp_wdata_d  = dp_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = 1'b0;

    if (HREADY) begin
      if (dp_valid_q) begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = dp_write_q ? 32'h0 : HRDATA;
        rsp_err_d   = HRESP | dp_ill_q;
      end
      dp_valid_d = ap_valid_q;
      dp_write_d = ap_write_q;
      dp_ill_d   = ap_ill_q;
      dp_wdata_d = ap_wdata_q;
      ap_valid_d = accept;
      if (accept) begin
        ap_addr_d  = addr_al;
        ap_write_d = cmd_write;
        // illegal size 3 goes out as a word
        ap_size_d  = (cmd_size == 2'd3) ? 2'd2 : cmd_size;
        ap_ill_d   = (cmd_size == 2'd3);
        ap_wdata_d = cmd_wdata;
      end
    end

`ifdef AHBL_CMD_MASTER_TIMEOUT_EN
    cnt_d    = cnt_q;
    rec_d    = 1'b0;
    rec_ap_d = 1'b0;
    rec_wr_d = 1'b0;
    flag_d   = flag_q;
    if (HREADY) begin
      cnt_d = 16'h0;
    end else if (dp_valid_q) begin
      cnt_d = cnt_q + 16'd1;
      if (cnt_d == TO_LIM) begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_rdata_d = dp_write_q ? 32'h0 : ERR_RDATA;
        dp_valid_d  = 1'b0;
        ap_valid_d  = 1'b0;
        rec_d       = 1'b1;
        rec_ap_d    = ap_valid_q;
        rec_wr_d    = ap_write_q;
        cnt_d       = 16'h0;
        flag_d      = 1'b1;
      end
    end
    // the dropped address-phase command answers one cycle later
    if (rec_q && rec_ap_q) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_rdata_d = rec_wr_q ? 32'h0 : ERR_RDATA;
    end
`endif
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_valid_q  <= 1'b0;
      ap_addr_q   <= 32'h0;
      ap_write_q  <= 1'b0;
      ap_size_q   <= 2'd0;
      ap_ill_q    <= 1'b0;
      ap_wdata_q  <= 32'h0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_ill_q    <= 1'b0;
      dp_wdata_q  <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      ap_valid_q  <= ap_valid_d;
      ap_addr_q   <= ap_addr_d;
      ap_write_q  <= ap_write_d;
      ap_size_q   <= ap_size_d;
      ap_ill_q    <= ap_ill_d;
      ap_wdata_q  <= ap_wdata_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_ill_q    <= dp_ill_d;
      dp_wdata_q  <= dp_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef AHBL_CMD_MASTER_TIMEOUT_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q    <= 16'h0;
      rec_q    <= 1'b0;
      rec_ap_q <= 1'b0;
      rec_wr_q <= 1'b0;
      flag_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rec_q    <= rec_d;
      rec_ap_q <= rec_ap_d;
      rec_wr_q <= rec_wr_d;
      flag_q   <= flag_d;
    end
  end
`endif

  assign HADDR     = ap_addr_q;
  assign HTRANS    = ap_valid_q ? TR_NONSEQ : TR_IDLE;
  assign HWRITE    = ap_write_q;
  assign HSIZE     = {1'b0, ap_size_q};
  assign HBURST    = 3'b000;
  assign HWDATA    = dp_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ahbl_cmd_master.sv
// Bench for ahbl_cmd_master: vector table, directed corners, random run.
`timescale 1ns/1ps
module tb_ahbl_cmd_master;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [1:0]  cmd_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
`ifdef AHBL_CMD_MASTER_TIMEOUT_EN
  logic        timeout_flag;
`endif

  always #5 HCLK = ~HCLK;

`ifdef AHBL_CMD_MASTER_TIMEOUT_EN
  ahbl_cmd_master #(.TIMEOUT(4)) dut (
`else
  ahbl_cmd_master dut (
`endif
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
`ifdef AHBL_CMD_MASTER_TIMEOUT_EN
    , .timeout_flag(timeout_flag)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [1:0]  sz;
    logic [31:0] wd;
    logic [31:0] hr;
    logic [31:0] e_addr;
    logic [2:0]  e_sz;
    logic [31:0] e_rd;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic        v;
    logic        w;
    logic [31:0] a;
    logic [1:0]  s;
    logic [31:0] d;
  } slot_t;

  vec_t  tbl [6];
  slot_t m_ap, m_dp, nc;
  logic        e_v, e_err;
  logic [31:0] e_rd;
  int          lowrun;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_in();
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_size  = 2'd0;
    cmd_wdata = 32'h0;
    HREADY    = 1'b1;
    HRDATA    = 32'h0;
    HRESP     = 1'b0;
  endtask

  task automatic put(input logic w, input logic [31:0] a,
                     input logic [1:0] s, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_size  = s;
    cmd_wdata = d;
  endtask

  function automatic logic [31:0] align(input logic [31:0] a,
                                        input logic [1:0] s);
    if (s == 2'd0) return a;
    if (s == 2'd1) return a & 32'hFFFF_FFFE;
    return a & 32'hFFFF_FFFC;
  endfunction

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_htrans"}, HTRANS, 2'b00);
    chk({tag, "_haddr"}, HADDR, 32'h0);
    chk({tag, "_hwrite"}, HWRITE, 1'b0);
    chk({tag, "_hsize"}, HSIZE, 3'b000);
    chk({tag, "_hwdata"}, HWDATA, 32'h0);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_rsp_err"}, rsp_err, 1'b0);
  endtask

  initial begin
    tbl[0] = '{1'b0, 32'h10, 2'd2, 32'h0, 32'h1234_5678,
               32'h10, 3'b010, 32'h1234_5678, 1'b0};
    tbl[1] = '{1'b0, 32'h3, 2'd0, 32'h0, 32'h0000_00AA,
               32'h3, 3'b000, 32'h0000_00AA, 1'b0};
    tbl[2] = '{1'b0, 32'h3, 2'd1, 32'h0, 32'h0000_BBBB,
               32'h2, 3'b001, 32'h0000_BBBB, 1'b0};
    tbl[3] = '{1'b0, 32'h7, 2'd3, 32'h0, 32'h0000_CAFE,
               32'h4, 3'b010, 32'h0000_CAFE, 1'b1};
    tbl[4] = '{1'b1, 32'h1003, 2'd2, 32'h55AA, 32'hFFFF,
               32'h1000, 3'b010, 32'h0, 1'b0};
    tbl[5] = '{1'b1, 32'h22, 2'd3, 32'h9, 32'h1,
               32'h20, 3'b010, 32'h0, 1'b1};

    idle_in();
    #12;
    chk_reset_outs("reset");
    chk("reset_hburst", HBURST, 3'b000);
    step();
    HRESETn = 1'b1;
    step();

    // single transfers from the vector table
    foreach (tbl[i]) begin
      put(tbl[i].w, tbl[i].addr, tbl[i].sz, tbl[i].wd);
      #1 chk("tbl_cmd_ready", cmd_ready, 1'b1);
      step();
      cmd_valid = 1'b0;
      chk("tbl_htrans_ap", HTRANS, 2'b10);
      chk("tbl_haddr", HADDR, tbl[i].e_addr);
      chk("tbl_hsize", HSIZE, tbl[i].e_sz);
      chk("tbl_hwrite", HWRITE, tbl[i].w);
      chk("tbl_hburst", HBURST, 3'b000);
      HRDATA = tbl[i].hr;
      step();
      chk("tbl_htrans_dp", HTRANS, 2'b00);
      chk("tbl_rsp_early", rsp_valid, 1'b0);
      if (tbl[i].w) chk("tbl_hwdata", HWDATA, tbl[i].wd);
      step();
      chk("tbl_rsp_valid", rsp_valid, 1'b1);
      chk("tbl_rsp_rdata", rsp_rdata, tbl[i].e_rd);
      chk("tbl_rsp_err", rsp_err, tbl[i].e_err);
      HRDATA = 32'h0;
      step();
      chk("tbl_rsp_pulse", rsp_valid, 1'b0);
    end

    // four back-to-back writes
    for (int k = 0; k < 6; k++) begin
      if (k < 4) put(1'b1, 32'h100 + 32'(4 * k), 2'd2, 32'(k + 1));
      else cmd_valid = 1'b0;
      step();
      chk("b2b_htrans", HTRANS, (k < 4) ? 2'b10 : 2'b00);
      if (k < 4) chk("b2b_haddr", HADDR, 32'h100 + 32'(4 * k));
      if (k >= 1 && k <= 4) chk("b2b_hwdata", HWDATA, 32'(k));
      chk("b2b_rsp_valid", rsp_valid, k >= 2);
    end
    cmd_valid = 1'b0;
    step();
    chk("b2b_rsp_end", rsp_valid, 1'b0);

    // read with three wait states, second command in address phase
    put(1'b0, 32'h40, 2'd2, 32'h0);
    step();
    put(1'b1, 32'h44, 2'd2, 32'hABCD);
    step();
    put(1'b0, 32'h48, 2'd2, 32'h0);
    HREADY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("ws_cmd_ready", cmd_ready, 1'b0);
      chk("ws_htrans", HTRANS, 2'b10);
      chk("ws_haddr", HADDR, 32'h44);
      chk("ws_hwrite", HWRITE, 1'b1);
      chk("ws_rsp", rsp_valid, 1'b0);
      step();
    end
    HREADY = 1'b1;
    HRDATA = 32'h600D;
    step();
    chk("ws_rsp_a_valid", rsp_valid, 1'b1);
    chk("ws_rsp_a_rdata", rsp_rdata, 32'h600D);
    chk("ws_rsp_a_err", rsp_err, 1'b0);
    chk("ws_haddr_c", HADDR, 32'h48);
    chk("ws_hwdata_b", HWDATA, 32'hABCD);
    cmd_valid = 1'b0;
    HRDATA = 32'h1111;
    step();
    chk("ws_rsp_b_valid", rsp_valid, 1'b1);
    chk("ws_rsp_b_rdata", rsp_rdata, 32'h0);
    step();
    chk("ws_rsp_c_valid", rsp_valid, 1'b1);
    chk("ws_rsp_c_rdata", rsp_rdata, 32'h1111);
    HRDATA = 32'h0;
    step();
    chk("ws_rsp_end", rsp_valid, 1'b0);

    // two-cycle error response on a write, read follows
    put(1'b1, 32'h2000, 2'd2, 32'hE1);
    step();
    put(1'b0, 32'h2004, 2'd2, 32'h0);
    step();
    cmd_valid = 1'b0;
    HREADY = 1'b0;
    HRESP  = 1'b1;
    step();
    chk("err_htrans_kept", HTRANS, 2'b10);
    chk("err_haddr_kept", HADDR, 32'h2004);
    chk("err_rsp_early", rsp_valid, 1'b0);
    HREADY = 1'b1;
    step();
    chk("err_w_valid", rsp_valid, 1'b1);
    chk("err_w_err", rsp_err, 1'b1);
    HRESP  = 1'b0;
    HRDATA = 32'h5151;
    step();
    chk("err_r_valid", rsp_valid, 1'b1);
    chk("err_r_err", rsp_err, 1'b0);
    chk("err_r_rdata", rsp_rdata, 32'h5151);
    HRDATA = 32'h0;
    step();
    chk("err_rsp_end", rsp_valid, 1'b0);

    // random traffic against a two-slot pipeline model
    m_ap   = '{1'b0, 1'b0, 32'h0, 2'd0, 32'h0};
    m_dp   = m_ap;
    lowrun = 0;
    for (int c = 0; c < 500; c++) begin
      nc.v = (c < 480) && ($urandom_range(0, 3) != 0);
      nc.w = 1'($urandom);
      nc.a = $urandom;
      nc.s = 2'($urandom_range(0, 3));
      nc.d = $urandom;
      if (lowrun >= 2 || c >= 480) HREADY = 1'b1;
      else HREADY = ($urandom_range(0, 2) != 0);
      lowrun = HREADY ? 0 : lowrun + 1;
      HRDATA    = $urandom;
      HRESP     = ($urandom_range(0, 5) == 0);
      cmd_valid = nc.v;
      cmd_write = nc.w;
      cmd_addr  = nc.a;
      cmd_size  = nc.s;
      cmd_wdata = nc.d;
      #1;
      chk("rnd_cmd_ready", cmd_ready, HREADY);
      e_v = 1'b0;
      if (HREADY) begin
        if (m_dp.v) begin
          e_v   = 1'b1;
          e_rd  = m_dp.w ? 32'h0 : HRDATA;
          e_err = HRESP | (m_dp.s == 2'd3);
          if (m_dp.w) chk("rnd_hwdata", HWDATA, m_dp.d);
        end
        m_dp = m_ap;
        m_ap = nc;
      end
      step();
      chk("rnd_htrans", HTRANS, m_ap.v ? 2'b10 : 2'b00);
      if (m_ap.v) begin
        chk("rnd_haddr", HADDR, align(m_ap.a, m_ap.s));
        chk("rnd_hwrite", HWRITE, m_ap.w);
        chk("rnd_hsize", HSIZE,
            {1'b0, (m_ap.s == 2'd3) ? 2'd2 : m_ap.s});
      end
      chk("rnd_rsp_valid", rsp_valid, e_v);
      if (e_v) begin
        chk("rnd_rsp_rdata", rsp_rdata, e_rd);
        chk("rnd_rsp_err", rsp_err, e_err);
      end
    end
    idle_in();
    step();

`ifdef AHBL_CMD_MASTER_TIMEOUT_EN
    // bus stuck with both stages full
    put(1'b0, 32'h50, 2'd2, 32'h0);
    step();
    put(1'b1, 32'h54, 2'd2, 32'h99);
    step();
    cmd_valid = 1'b0;
    HREADY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("to_wait_rsp", rsp_valid, 1'b0);
      chk("to_wait_htrans", HTRANS, 2'b10);
      chk("to_wait_flag", timeout_flag, 1'b0);
    end
    step();
    chk("to_dp_valid", rsp_valid, 1'b1);
    chk("to_dp_err", rsp_err, 1'b1);
    chk("to_dp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("to_htrans_idle", HTRANS, 2'b00);
    chk("to_flag_set", timeout_flag, 1'b1);
    HREADY = 1'b1;
    put(1'b0, 32'h60, 2'd2, 32'h0);
    #1 chk("to_rec_cmd_ready", cmd_ready, 1'b0);
    step();
    chk("to_ap_valid", rsp_valid, 1'b1);
    chk("to_ap_err", rsp_err, 1'b1);
    chk("to_ap_rdata", rsp_rdata, 32'h0);
    chk("to_rec_no_issue", HTRANS, 2'b00);
    cmd_valid = 1'b0;
    step();
    chk("to_after_rsp", rsp_valid, 1'b0);
    chk("to_flag_sticky", timeout_flag, 1'b1);
`endif

    // asynchronous reset in the middle of a waited write
    put(1'b1, 32'h30, 2'd2, 32'h77);
    step();
    cmd_valid = 1'b0;
    step();
    chk("mid_hwdata_pre", HWDATA, 32'h77);
    HREADY = 1'b0;
    step();
    #2 HRESETn = 1'b0;
    #1;
    chk_reset_outs("mid");
`ifdef AHBL_CMD_MASTER_TIMEOUT_EN
    chk("mid_flag", timeout_flag, 1'b0);
`endif
    step();
    HRESETn = 1'b1;
    HREADY  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_rsp", rsp_valid, 1'b0);
      chk("post_rst_htrans", HTRANS, 2'b00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahbl_cmd_master.md
Name: ahbl_cmd_master

Overview:
- AHB-Lite initiator that turns a simple valid/ready command stream into single (non-burst) AHB-Lite transfers.
- Sits between a local requester (CPU-side DMA engine or test sequencer) and the AHB-Lite interconnect that fronts the ROM, RAM and peripheral slaves.
- Fully pipelined: the address phase of command N+1 overlaps the data phase of command N.
- Each completed transfer returns exactly one response carrying read data and an error flag.

Parameters:
- TIMEOUT, 256: consecutive wait-state cycles before a data phase is aborted. Used only with the optional feature; legal range 2..65535.
- ERR_RDATA, 32'hDEADBEEF: value returned on rsp_rdata for aborted reads.

Ports:
- HCLK  input  1  bus clock; the only clock.
- HRESETn  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted this cycle when high together with cmd_valid.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  32  byte address.
- cmd_size  input  2  0 = byte, 1 = halfword, 2 = word; 3 is illegal.
- cmd_wdata  input  32  write data, already lane-aligned.
- rsp_valid  output  1  one-cycle response pulse; no backpressure.
- rsp_rdata  output  32  read data; 0 for writes.
- rsp_err  output  1  transfer failed.
- HADDR  output  32  AHB address.
- HTRANS  output  2  IDLE = 2'b00 or NONSEQ = 2'b10 only.
- HWRITE  output  1  AHB write flag.
- HSIZE  output  3  {1'b0, size}.
- HBURST  output  3  constant 3'b000 (SINGLE).
- HWDATA  output  32  write data, driven in the data phase.
- HREADY  input  1  interconnect ready.
- HRDATA  input  32  read data.
- HRESP  input  1  slave error.
- timeout_flag  output  1  sticky abort indicator; exists only with the optional feature.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - HTRANS = IDLE; HADDR, HWRITE, HSIZE, HWDATA all 0.
  - rsp_valid, rsp_err = 0; rsp_rdata = 0.
  - Both pipeline stages become empty. In-flight transfers are dropped with no response.
- Pipeline stages:
  - AP (address phase): ap_valid plus registered addr/write/size/wdata. It drives HADDR, HTRANS, HWRITE, HSIZE.
  - DP (data phase): dp_valid plus registered write/wdata. It drives HWDATA.
- cmd_ready = HREADY, combinational. In the timeout-recovery cycle cmd_ready is forced to 0.
- Advance rule: on each rising HCLK with HREADY = 1, all of the following happen:
  - If dp_valid, DP completes.
  - AP moves into DP.
  - An accepted command, if any, loads AP.
  - With no accepted command, AP empties and HTRANS becomes IDLE.
- While HREADY = 0, AP and DP hold and every AHB output is stable.
- Address alignment: HADDR low bits are forced to 0 according to size (halfword: bit 0; word: bits 1:0).
- cmd_size = 3 is accepted but issued as a word transfer, with rsp_err = 1 on its response.
- Responses:
  - A completing DP registers rsp_valid = 1 for one cycle.
  - rsp_rdata = HRDATA for reads and 0 for writes.
  - rsp_err = HRESP | illegal size.
- Latency with zero wait states: command accepted at edge 0 → address phase in cycle 1 → data phase in cycle 2 → rsp_valid high in cycle 3. Each wait state adds 1 cycle.
- Throughput: 1 transfer per cycle when HREADY stays high.
- Two-cycle HRESP error (HRESP = 1 with HREADY = 0, then HRESP = 1 with HREADY = 1):
  - The block does not cancel the following address phase.
  - The error is reported on the erroring transfer only.
  - The pipeline continues normally.
- Responses are emitted strictly in command order.

Optional Feature:
- Macro: AHBL_CMD_MASTER_TIMEOUT_EN.
- Defined:
  - A 16-bit counter increments on every cycle with dp_valid = 1 and HREADY = 0, and clears when HREADY = 1.
  - When the counter reaches TIMEOUT:
    - The DP transfer is responded with rsp_err = 1 and rsp_rdata = ERR_RDATA for reads (0 for writes).
    - If ap_valid, the AP command is responded with rsp_err = 1 on the next cycle.
    - Both stages empty, HTRANS goes to IDLE, and cmd_ready is 0 for that recovery cycle.
    - timeout_flag is set to 1 and stays set until reset.
- Not defined:
  - No counter; wait states are unbounded.
  - The timeout_flag port does not exist.
  - The TIMEOUT and ERR_RDATA parameters are ignored.

Test Plan:
- Single word read at 0x0000_0010 with zero wait states and HRDATA = 0x1234_5678:
  - HTRANS = NONSEQ for one cycle.
  - rsp_valid in cycle 3 with rsp_rdata = 0x1234_5678 and rsp_err = 0.
- Four back-to-back word writes to 0x100/0x104/0x108/0x10C, data 1..4, HREADY always 1:
  - HTRANS = NONSEQ for 4 consecutive cycles.
  - HWDATA = 1..4 each lagging HADDR by one cycle.
  - 4 consecutive rsp_valid pulses.
- Read with HREADY held low 3 cycles in the data phase, while a second command is pending:
  - HADDR/HTRANS of the second command stable through the wait.
  - cmd_ready = 0 during the wait.
  - First rsp_valid at cycle 6.
- Two-cycle HRESP error on a write to 0x2000 followed by a read of 0x2004:
  - Write response rsp_err = 1.
  - Read still issued and responded with rsp_err = 0.
- Byte read at cmd_addr = 0x0000_0003 with size = 0: HADDR = 0x3, HSIZE = 3'b000. Halfword at 0x3: HADDR = 0x2. cmd_size = 3: rsp_err = 1.
- With AHBL_CMD_MASTER_TIMEOUT_EN and TIMEOUT = 4, HREADY stuck at 0 with both stages full:
  - After 4 wait cycles, two error responses in consecutive cycles, the read returning 0xDEADBEEF.
  - timeout_flag = 1 until reset.
  - Reset asserted mid-wait returns all outputs to their reset values with no response.
